// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default geometry/width parameters, depth-test
// mode encodings and raster engine state encoding.
package gpu_pkg;
  localparam int TILE_BITS_DEF = 5;
  localparam int Z_W_DEF       = 27;
  localparam int COLOR_W_DEF   = 16;

  typedef enum logic [1:0] {
    MODE_LESS   = 2'b00,
    MODE_LEQUAL = 2'b01,
    MODE_ALWAYS = 2'b10,
    MODE_CLEAR  = 2'b11
  } depth_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_FLUSH = 2'b10
  } raster_state_e;
endpackage

// File: rtl/tile_depth_ram.sv
// Simple dual-port tile depth store: one synchronous write and one
// registered read per cycle.
module tile_depth_ram #(
  parameter int TILE_BITS = 5,
  parameter int Z_W       = 27
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [2*TILE_BITS-1:0] waddr,
  input  logic [Z_W-1:0]         wdata,
  input  logic [2*TILE_BITS-1:0] raddr,
  output logic [Z_W-1:0]         rdata
);
  localparam int DEPTH = 2 ** (2 * TILE_BITS);

  logic [Z_W-1:0] mem [DEPTH];
  logic [Z_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/tile_raster_engine.sv
// Tile rasteriser: scans an N x N tile row-major, evaluates three edge
// functions and a depth plane incrementally, and depth-tests each pixel.
module tile_raster_engine
  import gpu_pkg::*;
#(
  parameter int TILE_BITS = TILE_BITS_DEF,
  parameter int Z_W       = Z_W_DEF,
  parameter int COLOR_W   = COLOR_W_DEF,
  parameter int A_W       = 19,
  parameter int B_W       = 24,
  parameter int W_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [A_W-1:0] A01,
  input  logic signed [A_W-1:0] A12,
  input  logic signed [A_W-1:0] A20,
  input  logic signed [B_W-1:0] B01,
  input  logic signed [B_W-1:0] B12,
  input  logic signed [B_W-1:0] B20,
  input  logic signed [W_W-1:0] w0_in,
  input  logic signed [W_W-1:0] w1_in,
  input  logic signed [W_W-1:0] w2_in,
  input  logic [Z_W-1:0]        dzdx,
  input  logic [Z_W-1:0]        dzdy,
  input  logic [Z_W-1:0]        zC,
  input  logic [COLOR_W-1:0]    color_in,
  input  logic [1:0]            mode,
  input  logic                  zwrite,
  output logic [TILE_BITS-1:0]  X,
  output logic [TILE_BITS-1:0]  Y,
  output logic                  wren,
  output logic [COLOR_W-1:0]    color_out,
  output logic                  busy,
  output logic                  done
);
  raster_state_e         state_q, state_d;
  logic [1:0]            flush_q, flush_d;
  logic [TILE_BITS-1:0]  x_q, x_d, y_q, y_d;
  logic signed [W_W-1:0] a_q [3], a_d [3], b_q [3], b_d [3];
  logic signed [W_W-1:0] wrow_q [3], wrow_d [3], wcur_q [3], wcur_d [3];
  logic [Z_W-1:0]        dzdx_q, dzdx_d, dzdy_q, dzdy_d;
  logic [Z_W-1:0]        zrow_q, zrow_d, zcur_q, zcur_d;
  logic [COLOR_W-1:0]    color_q, color_d;
  depth_mode_e           mode_q, mode_d;
  logic                  zwrite_q, zwrite_d;

  logic                  s1_valid_q, s1_valid_d, s1_cov_q, s1_cov_d;
  logic [Z_W-1:0]        s1_z_q, s1_z_d;
  logic [TILE_BITS-1:0]  s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic                  wren_q, wren_d;
  logic [TILE_BITS-1:0]  xo_q, xo_d, yo_q, yo_d;
  logic [COLOR_W-1:0]    color_out_q, color_out_d;

  logic [Z_W-1:0]        rd_data, ram_wdata;
  logic                  ram_we, z_pass, is_clear;

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    x_d      = x_q;
    y_d      = y_q;
    a_d      = a_q;
    b_d      = b_q;
    wrow_d   = wrow_q;
    wcur_d   = wcur_q;
    dzdx_d   = dzdx_q;
    dzdy_d   = dzdy_q;
    zrow_d   = zrow_q;
    zcur_d   = zcur_q;
    color_d  = color_q;
    mode_d   = mode_q;
    zwrite_d = zwrite_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        a_d      = '{W_W'(A01), W_W'(A12), W_W'(A20)};
        b_d      = '{W_W'(B01), W_W'(B12), W_W'(B20)};
        wrow_d   = '{w0_in, w1_in, w2_in};
        wcur_d   = '{w0_in, w1_in, w2_in};
        dzdx_d   = dzdx;
        dzdy_d   = dzdy;
        zrow_d   = zC;
        zcur_d   = zC;
        color_d  = color_in;
        mode_d   = depth_mode_e'(mode);
        zwrite_d = zwrite;
        x_d      = '0;
        y_d      = '0;
        state_d  = ST_SCAN;
      end
      ST_SCAN: begin
        if (x_q == '1) begin
          // Row end: step from the saved row start, not the running value.
          x_d = '0;
          y_d = y_q + TILE_BITS'(1);
          for (int unsigned i = 0; i < 3; i++) begin
            wrow_d[i] = wrow_q[i] + b_q[i];
            wcur_d[i] = wrow_q[i] + b_q[i];
          end
          zrow_d = zrow_q + dzdy_q;
          zcur_d = zrow_q + dzdy_q;
          if (y_q == '1) begin
            flush_d = '0;
            state_d = ST_FLUSH;
          end
        end else begin
          x_d = x_q + TILE_BITS'(1);
          for (int unsigned i = 0; i < 3; i++) wcur_d[i] = wcur_q[i] + a_q[i];
          zcur_d = zcur_q + dzdx_q;
        end
      end
      ST_FLUSH: begin
        flush_d = flush_q + 2'd1;
        if (flush_q == 2'd2) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = (state_q == ST_SCAN);
    s1_cov_d   = ~(wcur_q[0][W_W-1] | wcur_q[1][W_W-1] | wcur_q[2][W_W-1]);
    s1_z_d     = zcur_q;
    s1_x_d     = x_q;
    s1_y_d     = y_q;
    unique case (mode_q)
      MODE_LESS:   z_pass = (s1_z_q < rd_data);
      MODE_LEQUAL: z_pass = (s1_z_q <= rd_data);
      default:     z_pass = 1'b1;
    endcase
    is_clear    = (mode_q == MODE_CLEAR);
    ram_we      = s1_valid_q & (is_clear | (s1_cov_q & z_pass & zwrite_q));
    ram_wdata   = is_clear ? '1 : s1_z_q;
    wren_d      = s1_valid_q & (is_clear | (s1_cov_q & z_pass));
    xo_d        = s1_x_q;
    yo_d        = s1_y_q;
    color_out_d = color_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      wrow_q      <= '{default: '0};
      wcur_q      <= '{default: '0};
      dzdx_q      <= '0;
      dzdy_q      <= '0;
      zrow_q      <= '0;
      zcur_q      <= '0;
      color_q     <= '0;
      mode_q      <= MODE_LESS;
      zwrite_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_cov_q    <= 1'b0;
      s1_z_q      <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      wren_q      <= 1'b0;
      xo_q        <= '0;
      yo_q        <= '0;
      color_out_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      x_q         <= x_d;
      y_q         <= y_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wrow_q      <= wrow_d;
      wcur_q      <= wcur_d;
      dzdx_q      <= dzdx_d;
      dzdy_q      <= dzdy_d;
      zrow_q      <= zrow_d;
      zcur_q      <= zcur_d;
      color_q     <= color_d;
      mode_q      <= mode_d;
      zwrite_q    <= zwrite_d;
      s1_valid_q  <= s1_valid_d;
      s1_cov_q    <= s1_cov_d;
      s1_z_q      <= s1_z_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      wren_q      <= wren_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      color_out_q <= color_out_d;
    end
  end

  tile_depth_ram #(
    .TILE_BITS (TILE_BITS),
    .Z_W       (Z_W)
  ) u_depth_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({s1_y_q, s1_x_q}),
    .wdata (ram_wdata),
    .raddr ({y_q, x_q}),
    .rdata (rd_data)
  );

  assign X         = xo_q;
  assign Y         = yo_q;
  assign wren      = wren_q;
  assign color_out = color_out_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = ~busy;
endmodule
